// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, the captured request record and the
// byte-lane count used by the responder, its store and its interface.
package dmem_responder_pkg;

    // Byte lanes per 32-bit data word.
    localparam int NUM_LANES = 4;

    // Responder FSM states. The names carry a prefix because 'wait' is a keyword.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One load/store request as captured on acceptance.
    typedef struct packed {
        logic                 we;
        logic [31:0]          addr;
        logic [31:0]          wdata;
        logic [NUM_LANES-1:0] wstrb;
    } req_t;

    // A word access must have its two low address bits clear.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's load/store path (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic [NUM_LANES-1:0] req_wstrb;
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_rsp_store.sv
// Word-organised data store built as one byte-wide array per lane, so
// each lane maps onto block RAM with its own write enable. Single
// address port; the read data is registered and only updates when
// rd_en is high, so it holds the last load result indefinitely.
// Contents are not reset.
module dmem_rsp_store
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic [AW-1:0]        addr,
    input  logic [NUM_LANES-1:0] wr_en,
    input  logic [31:0]          wdata,
    input  logic                 rd_en,
    output logic [31:0]          rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rdata_q;

            // Per-lane byte write and registered read.
            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    mem[addr] <= wdata[8*gi +: 8];
                end
                if (rd_en) begin
                    rdata_q <= mem[addr];
                end
            end

            assign rdata[8*gi +: 8] = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle responder for the CPU data port.
// Accepts one load/store at a time, waits WAIT_CYCLES wait states,
// executes the access on the edge that enters RESP and emits a
// one-cycle response pulse. Misaligned accesses are rejected.
// Optional feature: define DMEM_RSP_RANGE_CHK_EN to also reject any
// address with set bits above the word-index field; otherwise upper
// address bits are ignored and addresses alias modulo DEPTH_WORDS*4.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Counter preload on acceptance; unused when there are no wait states.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        load_q, load_d;

    req_t        req_live;
    req_t        exec_req;
    logic        exec;
    logic        addr_err;
    logic        range_err;
    logic [AW-1:0]        ram_addr;
    logic [NUM_LANES-1:0] ram_wr_en;
    logic        ram_rd_en;
    logic [31:0] ram_rdata;

    // Upper address bits either flag an error or are deliberately ignored.
`ifdef DMEM_RSP_RANGE_CHK_EN
    assign range_err = (exec_req.addr[31:AW+2] != '0);
`else
    logic unused_upper_addr;
    assign range_err         = 1'b0;
    assign unused_upper_addr = ^exec_req.addr[31:AW+2];
`endif

    // Next-state logic: FSM, wait counter, request capture and the
    // selection of which request executes this edge. With no wait
    // states the access executes on the acceptance edge itself, so the
    // live bus request is used directly instead of the captured copy.
    always_comb begin
        req_live.we    = bus.req_we;
        req_live.addr  = bus.req_addr;
        req_live.wdata = bus.req_wdata;
        req_live.wstrb = bus.req_wstrb;

        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        exec     = 1'b0;
        exec_req = req_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    req_d = req_live;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d  = ST_RESP;
                        exec     = 1'b1;
                        exec_req = req_live;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    exec    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Access decode for the executing request: errors suppress both the
    // write and the read, so rejected accesses touch nothing.
    always_comb begin
        addr_err  = is_misaligned(exec_req.addr) || range_err;
        ram_addr  = exec_req.addr[AW+1:2];
        ram_wr_en = '0;
        ram_rd_en = 1'b0;
        if (exec && !addr_err) begin
            if (exec_req.we) begin
                ram_wr_en = exec_req.wstrb;
            end else begin
                ram_rd_en = 1'b1;
            end
        end
    end

    // Output register next values: handshake flags follow the next state,
    // response qualifiers update only when an access executes.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_RESP);
        err_d   = exec ? addr_err  : err_q;
        load_d  = exec ? ram_rd_en : load_q;
    end

    // State and output registers with asynchronous reset; an in-flight
    // request is discarded, so a pending store never reaches the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    dmem_rsp_store #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_store (
        .clk   (clk),
        .addr  (ram_addr),
        .wr_en (ram_wr_en),
        .wdata (exec_req.wdata),
        .rd_en (ram_rd_en),
        .rdata (ram_rdata)
    );

    // The store's read register holds the last load word; it is shown only
    // when the most recent response was a successful load.
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = load_q ? ram_rdata : 32'h0;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle responder for the CPU data port: accepts one load/store request at a time over a valid/ready handshake, applies a configurable wait-state latency, then returns one response pulse. It sits between the core's load/store path and a word-organised data store with byte-lane writes. Misaligned accesses and, optionally, out-of-range accesses are flagged as errors.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the store (power of two).
- WAIT_CYCLES, 2: wait states between request acceptance and response (0–15).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte-lane enables for stores; bit i writes req_wdata[8i+7:8i].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid; the access was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid=1, capture we/addr/wdata/wstrb. Go to WAIT if WAIT_CYCLES>0, else go to RESP.
- WAIT: req_ready=0. The wait counter is loaded with WAIT_CYCLES−1 on acceptance and decrements each cycle. Go to RESP on the edge where the counter is 0.
- RESP entry edge: the access executes and the response registers are loaded.
  - Load: rsp_rdata = mem[word index].
  - Store: lanes with wstrb=1 are written; other lanes are unchanged. rsp_rdata=0.
  - A store with wstrb=4'b0000 is legal. It responds normally and changes nothing.
- RESP: rsp_valid=1 for exactly one cycle, req_ready=0. Always returns to IDLE. There is no response backpressure.
- Word index is captured addr[log2(DEPTH_WORDS)+1:2].
- Error conditions:
  - addr[1:0]≠0 → rsp_err=1, rsp_rdata=0, no write.
  - Out-of-range addresses: see Configuration.
- Inputs are ignored outside IDLE. A request held high through a busy period is accepted on the next IDLE cycle.
- Reset, at any time: FSM→IDLE, counter→0, captured request discarded. A store not yet at its RESP entry edge is never performed. Memory contents are not reset.

## Timing
- Output values during reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Latency: from the acceptance edge to rsp_valid high is WAIT_CYCLES+1 cycles.
- Throughput: one request per WAIT_CYCLES+2 cycles. req_ready rises the cycle after rsp_valid.
- rsp_rdata and rsp_err are registered. They hold their values after RESP until the next RESP entry.
- A load issued after a store to the same word returns the stored data, because requests are strictly serialised.

## Configuration
- DMEM_RSP_RANGE_CHK_EN defined:
  - Any address with set bits above addr[log2(DEPTH_WORDS)+1] is an error.
  - Such an address returns rsp_err=1 and rsp_rdata=0, and no write occurs.
- DMEM_RSP_RANGE_CHK_EN undefined:
  - Upper address bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
  - Only misalignment raises rsp_err.

## Structure
- The shared package holds:
  - the FSM state enum (IDLE/WAIT/RESP);
  - a request struct (we, addr, wdata, wstrb);
  - a constant for the byte-lane count (4).
- One sub-module, dmem_rsp_store: synchronous word array with a 4-bit lane write enable and a registered read port.
- FSM, counter, error check and output registers live in dmem_responder.

## Test plan
- Reset, then release: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Assert rst during WAIT of a store to 0x10 → no rsp_valid; a later load of 0x10 returns the prior contents.
- Store 0x10, wdata 0xDEADBEEF, wstrb 4'hF, then load 0x10 (WAIT_CYCLES=2) → store response 3 cycles after acceptance with rsp_err=0; load returns 0xDEADBEEF; req_ready is low for 3 cycles per request.
- Store 0x20 = 0x11223344 (wstrb 4'hF), then store 0x20 = 0xAABBCCDD with wstrb 4'b0101 → load 0x20 returns 0x11BB33DD. A store with wstrb 0 leaves 0x11BB33DD.
- Load 0x22 → rsp_err=1, rsp_rdata=0. Store 0x26 with wstrb 4'hF → rsp_err=1 and memory unchanged.
- With DMEM_RSP_RANGE_CHK_EN defined, load 0x400 (DEPTH_WORDS=256) → rsp_err=1. With it undefined, store 0x400 = 0x5A5A5A5A, then load 0x0 → 0x5A5A5A5A.
- Hold req_valid continuously with WAIT_CYCLES=0 → each accepted request gets rsp_valid the next cycle; accepts occur every 2 cycles; 4 back-to-back loads return in order.
